// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshake and RAM port bundle for mem_lsu.
interface mem_lsu_if #(parameter int ADDR_WIDTH = 16);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data;
  logic [3:0]            mem_wren;
  logic [31:0]           mem_q;
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_q,
    input  req_ready, resp_valid, resp_rdata, mem_address, mem_data, mem_wren
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_q,
    output req_ready, resp_valid, resp_rdata, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: byte/halfword/word load-store unit onto a 32-bit RAM, splitting accesses
// that straddle a word boundary into two RAM accesses.
module mem_lsu #(parameter int ADDR_WIDTH = 16) (
  input logic     clock,
  input logic     reset_n,
  mem_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE2, CAP1, CAP2, DONE} state_t;
  state_t                state;
  logic                  wr, sgn, split;
  logic [1:0]            off, sz;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [31:0]           data_hi, lo_q;
  logic [3:0]            wren_hi;
  logic [1:0]            a_sz;
  logic [3:0]            a_mask;
  logic [7:0]            a_lanes;
  logic [63:0]           a_data;
  logic [ADDR_WIDTH-1:0] a_w;
  logic [31:0]           lo_w, rd;
  logic [63:0]           rd_sh;
  assign bus.req_ready = state == IDLE;
  always_comb begin
    a_sz    = bus.req_size[1] ? 2'd2 : bus.req_size;
    a_mask  = a_sz == 2'd0 ? 4'b0001 : a_sz == 2'd1 ? 4'b0011 : 4'b1111;
    a_lanes = {4'b0000, a_mask} << bus.req_addr[1:0];
    a_data  = {32'b0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
    a_w     = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    lo_w    = state == CAP2 ? lo_q : bus.mem_q;
    rd_sh   = {bus.mem_q, lo_w} >> {off, 3'b000};
    rd      = sz == 2'd0 ? {{24{sgn & rd_sh[7]}}, rd_sh[7:0]} :
              sz == 2'd1 ? {{16{sgn & rd_sh[15]}}, rd_sh[15:0]} : rd_sh[31:0];
  end
  // A split load responds as its second word arrives (leaving CAP2); DONE is then a tail cycle.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      wr              <= 1'b0;
      sgn             <= 1'b0;
      split           <= 1'b0;
      off             <= 2'd0;
      sz              <= 2'd0;
      addr_hi         <= '0;
      data_hi         <= '0;
      wren_hi         <= '0;
      lo_q            <= '0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
      bus.mem_wren    <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_rdata  <= '0;
    end else begin
      bus.mem_wren   <= 4'b0000;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          wr              <= bus.req_write;
          sgn             <= bus.req_signed;
          split           <= |a_lanes[7:4];
          off             <= bus.req_addr[1:0];
          sz              <= a_sz;
          addr_hi         <= a_w + ADDR_WIDTH'(4);
          data_hi         <= a_data[63:32];
          wren_hi         <= a_lanes[7:4];
          bus.mem_address <= a_w;
          if (bus.req_write) begin
            bus.mem_wren <= a_lanes[3:0];
            bus.mem_data <= a_data[31:0];
          end
          state <= |a_lanes[7:4] ? ISSUE2 : bus.req_write ? DONE : CAP1;
        end
        ISSUE2: begin
          bus.mem_address <= addr_hi;
          if (wr) begin
            bus.mem_wren <= wren_hi;
            bus.mem_data <= data_hi;
          end
          state <= wr ? DONE : CAP1;
        end
        CAP1: begin
          lo_q  <= bus.mem_q;
          state <= split ? CAP2 : DONE;
        end
        CAP2: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= rd;
          state          <= DONE;
        end
        DONE: begin
          if (wr || !split) begin
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= wr ? 32'h0 : rd;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
